alu_uart_sequencer: RTL and testbench

//  Shared-resource controller for the ALU + UART_TX datapath. Two requesters submit
//  (a, b, opcode) jobs; a round-robin arbiter grants one and drives the ALU, then

---
 rtl/alu_uart_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_uart_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_sequencer.sv
// Round-robin scheduler for two ALU job requesters: runs the ALU, then ships the 16-bit result
// over UART_TX as two bytes (plus an XOR checksum byte when SEQ_CHECKSUM_EN is defined).
module alu_uart_sequencer #(
    parameter int LSB_FIRST = 1,
    parameter int ALU_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [2:0]  req1_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic        uart_start,
    output logic [7:0]  uart_data,
    input  logic        uart_busy,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [15:0] resp_result,
    output logic        seq_busy
);

    typedef enum logic [3:0] {
        IDLE, EXEC, SEND0, ACK0, WAIT0, SEND1, ACK1, WAIT1,
`ifdef SEQ_CHECKSUM_EN
        SENDC, ACKC, WAITC,
`endif
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        rr_ptr;
    logic        owner;
    logic [3:0]  exec_cnt;
    logic [15:0] result_q;
    logic [7:0]  data_nx;
    logic        accept;
    logic        exec_last;
    logic [15:0] cur_result;
    logic [7:0]  byte_first;
    logic [7:0]  byte_second;

    // Readies are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        req0_ready = !reset && (state == IDLE) && req0_valid && (!req1_valid || !rr_ptr);
        req1_ready = !reset && (state == IDLE) && req1_valid && (!req0_valid || rr_ptr);
    end

    assign accept     = req0_ready | req1_ready;
    assign exec_last  = (state == EXEC) && (exec_cnt == 4'(ALU_LAT - 1));
    // On the last EXEC cycle the result is not yet in result_q, so take it straight from the ALU.
    assign cur_result = exec_last ? alu_result : result_q;

    always_comb begin
        byte_first  = cur_result[7:0];
        byte_second = cur_result[15:8];
        if (LSB_FIRST == 0) begin
            byte_first  = cur_result[15:8];
            byte_second = cur_result[7:0];
        end
    end

    always_comb begin
        state_nx   = state;
        data_nx    = uart_data;
        uart_start = 1'b0;
        case (state)
            IDLE:  if (accept) state_nx = EXEC;
            EXEC:  if (exec_last) begin
                       state_nx = SEND0;
                       data_nx  = byte_first;
                   end
            SEND0: if (!uart_busy) begin
                       uart_start = 1'b1;
                       state_nx   = ACK0;
                   end
            ACK0:  if (uart_busy) state_nx = WAIT0;
            WAIT0: if (!uart_busy) begin
                       state_nx = SEND1;
                       data_nx  = byte_second;
                   end
            SEND1: if (!uart_busy) begin
                       uart_start = 1'b1;
                       state_nx   = ACK1;
                   end
            ACK1:  if (uart_busy) state_nx = WAIT1;
`ifdef SEQ_CHECKSUM_EN
            WAIT1: if (!uart_busy) begin
                       state_nx = SENDC;
                       data_nx  = result_q[15:8] ^ result_q[7:0];
                   end
            SENDC: if (!uart_busy) begin
                       uart_start = 1'b1;
                       state_nx   = ACKC;
                   end
            ACKC:  if (uart_busy) state_nx = WAITC;
            WAITC: if (!uart_busy) state_nx = DONE;
`else
            WAIT1: if (!uart_busy) state_nx = DONE;
`endif
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            exec_cnt    <= '0;
            result_q    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            uart_data   <= '0;
            resp_id     <= 1'b0;
            resp_result <= '0;
        end else begin
            state     <= state_nx;
            uart_data <= data_nx;
            if (accept) begin
                rr_ptr   <= req0_ready;
                owner    <= req1_ready;
                alu_a    <= req1_ready ? req1_a  : req0_a;
                alu_b    <= req1_ready ? req1_b  : req0_b;
                alu_op   <= req1_ready ? req1_op : req0_op;
                exec_cnt <= '0;
            end else if (state == EXEC) begin
                exec_cnt <= exec_cnt + 4'd1;
            end
            if (exec_last) result_q <= alu_result;
            // Response registers only change on the way into DONE so they hold between jobs.
            if (state_nx == DONE && state != DONE) begin
                resp_id     <= owner;
                resp_result <= result_q;
            end
        end
    end

    assign resp_valid = (state == DONE);
    assign seq_busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
`timescale 1ns/1ps
// Two sequencer instances (LSB-first/ALU_LAT=1 and MSB-first/ALU_LAT=3) with behavioural ALU and
// UART_TX models; directed vector table, random jobs against a reference model, corner sequences.
module tb_alu_uart_sequencer;
    localparam int FRAME = 4;
`ifdef SEQ_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic r0v[2], r0r[2], r1v[2], r1r[2];
    logic [7:0] r0a[2], r0b[2], r1a[2], r1b[2];
    logic [2:0] r0o[2], r1o[2];
    logic [7:0] aa[2], ab[2];
    logic [2:0] ao[2];
    logic [15:0] ares[2];
    logic ust[2], ubusy[2], ubint[2], fbusy[2];
    logic [7:0] udat[2];
    logic rv[2], rid[2], sbusy[2];
    logic [15:0] rres[2];

    int ucnt[2];
    logic [7:0] held[2];
    logic [7:0] sent[2][0:1023];
    int nsent[2] = '{0, 0};
    int rcount[2] = '{0, 0};
    int err_start = 0, err_data = 0, err_rdy = 0;
    int n_chk = 0, n_fail = 0;
    int ptr[2];
    int snap_sent[2], snap_resp[2];

    typedef struct {
        int k; int sel;
        logic [7:0] a, b; logic [2:0] op;
        logic [15:0] res; logic [7:0] b0, b1, bc;
    } vec_t;
    vec_t tbl[7];

    always #5 clock = ~clock;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        alu_uart_sequencer #(.LSB_FIRST(k == 0 ? 1 : 0), .ALU_LAT(k == 0 ? 1 : 3)) dut (
            .clock(clock), .reset(reset),
            .req0_valid(r0v[k]), .req0_ready(r0r[k]), .req0_a(r0a[k]), .req0_b(r0b[k]), .req0_op(r0o[k]),
            .req1_valid(r1v[k]), .req1_ready(r1r[k]), .req1_a(r1a[k]), .req1_b(r1b[k]), .req1_op(r1o[k]),
            .alu_a(aa[k]), .alu_b(ab[k]), .alu_op(ao[k]), .alu_result(ares[k]),
            .uart_start(ust[k]), .uart_data(udat[k]), .uart_busy(ubusy[k]),
            .resp_valid(rv[k]), .resp_id(rid[k]), .resp_result(rres[k]), .seq_busy(sbusy[k]));
    end

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return 16'(a) + 16'(b);
            3'd1: return 16'(a) - 16'(b);
            3'd2: return 16'(a) * 16'(b);
            3'd3: return {8'h00, a & b};
            3'd4: return {8'h00, a | b};
            3'd5: return {8'h00, a ^ b};
            3'd6: return {a, b};
            default: return {b, a};
        endcase
    endfunction

    // Instance 0 sends the low byte first, instance 1 the high byte; slot 2 is the checksum.
    function automatic logic [7:0] exp_byte(input int k, input logic [15:0] r, input int slot);
        if (slot == 2) return r[7:0] ^ r[15:8];
        if ((k == 0) == (slot == 0)) return r[7:0];
        return r[15:8];
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ares[k]  = alu_fn(aa[k], ab[k], ao[k]);
            ubusy[k] = ubint[k] | fbusy[k];
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                ubint[k] <= 1'b0;
                ucnt[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ust[k] && !ubusy[k]) begin
                    sent[k][nsent[k][9:0]] <= udat[k];
                    nsent[k] <= nsent[k] + 1;
                    held[k]  <= udat[k];
                    ubint[k] <= 1'b1;
                    ucnt[k]  <= FRAME;
                end else if (ubint[k]) begin
                    ucnt[k] <= ucnt[k] - 1;
                    if (ucnt[k] == 1) ubint[k] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if ((r0r[k] && r1r[k]) || ((r0r[k] || r1r[k]) && sbusy[k])) err_rdy <= err_rdy + 1;
            if (ust[k] && ubusy[k]) err_start <= err_start + 1;
            if (ubint[k] && udat[k] != held[k]) err_data <= err_data + 1;
            if (rv[k]) rcount[k] <= rcount[k] + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic submit(input int k, input int pat,
                          input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] o0,
                          input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] o1);
        int w_exp;
        int won;
        bit got;
        w_exp = (pat == 1) ? 0 : (pat == 2) ? 1 : ptr[k];
        snap_sent[k] = nsent[k];
        snap_resp[k] = rcount[k];
        @(posedge clock); #1;
        r0a[k] = a0; r0b[k] = b0; r0o[k] = o0;
        r1a[k] = a1; r1b[k] = b1; r1o[k] = o1;
        r0v[k] = (pat != 2);
        r1v[k] = (pat != 1);
        got = 1'b0;
        won = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (r0r[k] || r1r[k]) begin
                got = 1'b1;
                won = r1r[k] ? 1 : 0;
            end
        end
        check("accept", 32'(got), 1);
        check("grant", won, w_exp);
        @(posedge clock); #1;
        r0v[k] = 1'b0; r1v[k] = 1'b0;
        r0a[k] = 8'($urandom); r0b[k] = 8'($urandom); r0o[k] = 3'($urandom);
        r1a[k] = 8'($urandom); r1b[k] = 8'($urandom); r1o[k] = 3'($urandom);
        #1;
        check("alu_a reg", aa[k], (w_exp == 1) ? a1 : a0);
        check("alu_op reg", ao[k], (w_exp == 1) ? o1 : o0);
        if (got) ptr[k] = 1 - won;
    endtask

    task automatic finish_job(input int k, input logic exp_id, input logic [15:0] exp_res,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] ec);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (rv[k]) begin
                seen = 1'b1;
                check("resp_id", rid[k], exp_id);
                check("resp_result", rres[k], exp_res);
                check("busy in done", sbusy[k], 1);
            end
        end
        check("resp seen", 32'(seen), 1);
        @(negedge clock);
        check("resp pulse width", rv[k], 0);
        check("resp hold", rres[k], exp_res);
        check("idle after job", sbusy[k], 0);
        check("byte count", nsent[k] - snap_sent[k], NB);
        check("byte 0", sent[k][snap_sent[k]], e0);
        check("byte 1", sent[k][snap_sent[k] + 1], e1);
`ifdef SEQ_CHECKSUM_EN
        check("checksum byte", sent[k][snap_sent[k] + 2], ec);
`else
        if (ec != (e0 ^ e1)) $display("note: inconsistent checksum vector");
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, actual running required finished");
        $fatal(1);
    end

    initial begin
        int n, k, pat, w;
        int order[3];
        bit idle, reached;
        logic [7:0] a0, b0, a1, b1;
        logic [2:0] o0, o1;
        logic [15:0] res;

        tbl[0] = '{0, 0, 8'h05, 8'h0A, 3'd0, 16'h000F, 8'h0F, 8'h00, 8'h0F};
        tbl[1] = '{0, 1, 8'hFF, 8'h01, 3'd0, 16'h0100, 8'h00, 8'h01, 8'h01};
        tbl[2] = '{0, 0, 8'hFF, 8'hFF, 3'd2, 16'hFE01, 8'h01, 8'hFE, 8'hFF};
        tbl[3] = '{0, 1, 8'h12, 8'h34, 3'd6, 16'h1234, 8'h34, 8'h12, 8'h26};
        tbl[4] = '{1, 0, 8'h05, 8'h0A, 3'd0, 16'h000F, 8'h00, 8'h0F, 8'h0F};
        tbl[5] = '{1, 1, 8'h12, 8'h34, 3'd6, 16'h1234, 8'h12, 8'h34, 8'h26};
        tbl[6] = '{0, 0, 8'h03, 8'h05, 3'd1, 16'hFFFE, 8'hFE, 8'hFF, 8'h01};

        for (int i = 0; i < 2; i++) begin
            r0v[i] = 1'b1; r1v[i] = 1'b1; fbusy[i] = 1'b0; ptr[i] = 0;
            r0a[i] = 8'h00; r0b[i] = 8'h00; r0o[i] = 3'd0;
            r1a[i] = 8'h00; r1b[i] = 8'h00; r1o[i] = 3'd0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check("reset req0_ready", r0r[i], 0);
            check("reset req1_ready", r1r[i], 0);
            check("reset alu_a", aa[i], 0);
            check("reset alu_op", ao[i], 0);
            check("reset uart_start", ust[i], 0);
            check("reset uart_data", udat[i], 0);
            check("reset resp_valid", rv[i], 0);
            check("reset resp_result", rres[i], 0);
            check("reset seq_busy", sbusy[i], 0);
            r0v[i] = 1'b0; r1v[i] = 1'b0;
        end
        @(posedge clock); #1;
        reset = 1'b0;

        // Both requesters held valid straight out of reset: req0, req1, req0.
        order = '{-1, -1, -1};
        snap_resp[0] = rcount[0];
        r0a[0] = 8'h05; r0b[0] = 8'h0A; r0o[0] = 3'd0;
        r1a[0] = 8'hFF; r1b[0] = 8'h01; r1o[0] = 3'd0;
        r0v[0] = 1'b1; r1v[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 2000 && n < 3; i++) begin
            @(negedge clock);
            if (r0r[0]) begin order[n] = 0; n++; end
            else if (r1r[0]) begin order[n] = 1; n++; end
        end
        @(posedge clock); #1;
        r0v[0] = 1'b0; r1v[0] = 1'b0;
        check("held accepts", n, 3);
        check("held order 0", order[0], 0);
        check("held order 1", order[1], 1);
        check("held order 2", order[2], 0);
        idle = 1'b0;
        for (int i = 0; i < 400 && !idle; i++) begin
            @(negedge clock);
            idle = !sbusy[0];
        end
        check("held drained", 32'(idle), 1);
        check("held resp count", rcount[0] - snap_resp[0], 3);
        check("held last id", rid[0], 0);
        check("held last result", rres[0], 16'h000F);
        ptr[0] = 1;

        for (int i = 0; i < 7; i++) begin
            submit(tbl[i].k, tbl[i].sel + 1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].op);
            finish_job(tbl[i].k, 1'(tbl[i].sel), tbl[i].res, tbl[i].b0, tbl[i].b1, tbl[i].bc);
        end

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 1);
            pat = $urandom_range(1, 3);
            a0 = 8'($urandom); b0 = 8'($urandom); o0 = 3'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom); o1 = 3'($urandom);
            w = (pat == 1) ? 0 : (pat == 2) ? 1 : ptr[k];
            res = (w == 1) ? alu_fn(a1, b1, o1) : alu_fn(a0, b0, o0);
            submit(k, pat, a0, b0, o0, a1, b1, o1);
            finish_job(k, 1'(w), res, exp_byte(k, res, 0), exp_byte(k, res, 1), exp_byte(k, res, 2));
        end

        // UART busy stuck high before the first byte: no start until it drops.
        fbusy[0] = 1'b1;
        submit(0, 1, 8'h21, 8'h43, 3'd0, 8'h00, 8'h00, 3'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (ust[0]) n++;
        end
        check("stuck start count", n, 0);
        check("stuck seq_busy", sbusy[0], 1);
        check("stuck no resp", rcount[0] - snap_resp[0], 0);
        check("stuck no bytes", nsent[0] - snap_sent[0], 0);
        @(posedge clock); #1;
        fbusy[0] = 1'b0;
        finish_job(0, 1'b0, 16'h0064, 8'h64, 8'h00, 8'h64);

        // Reset while the second byte is on the wire drops the job.
        submit(0, 2, 8'h00, 8'h00, 3'd0, 8'h80, 8'h80, 3'd0);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clock);
            reached = (nsent[0] - snap_sent[0] == 2);
        end
        check("second byte started", 32'(reached), 1);
        @(posedge clock); #1;
        check("pre-reset seq_busy", sbusy[0], 1);
        reset = 1'b1;
        #2;
        check("mid-reset uart_start", ust[0], 0);
        check("mid-reset seq_busy", sbusy[0], 0);
        check("mid-reset resp_valid", rv[0], 0);
        @(posedge clock); #1;
        reset = 1'b0;
        ptr[0] = 0;
        ptr[1] = 0;
        snap_resp[0] = rcount[0];
        snap_sent[0] = nsent[0];
        repeat (20) @(negedge clock);
        check("dropped job no resp", rcount[0] - snap_resp[0], 0);
        check("dropped job no bytes", nsent[0] - snap_sent[0], 0);
        submit(0, 1, 8'h05, 8'h0A, 3'd0, 8'h00, 8'h00, 3'd0);
        finish_job(0, 1'b0, 16'h000F, 8'h0F, 8'h00, 8'h0F);

        repeat (2) @(negedge clock);
        check("ready exclusivity", err_rdy, 0);
        check("start while busy", err_start, 0);
        check("uart_data stable", err_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
